// File: rtl/sorter_share_ctrl_if.sv
// sorter_share_ctrl_if: requester, sorter and result signals of the sorter share controller.
// master: environment side (requesters + sorter) ; slave: the controller.
// Ports: req/din/dv per requester, gnt per requester, srt_in*, srt_out*, dout*, busy, err.
interface sorter_share_ctrl_if;
  logic              req0;
  logic              req1;
  logic signed [7:0] din0;
  logic signed [7:0] din1;
  logic              dv0;
  logic              dv1;
  logic              gnt0;
  logic              gnt1;
  logic signed [7:0] srt_in;
  logic              srt_in_valid;
  logic signed [7:0] srt_out;
  logic              srt_out_valid;
  logic signed [7:0] dout;
  logic              dout_valid;
  logic              dout_id;
  logic              busy;
  logic              err;

  modport master (
    output req0, req1, din0, din1, dv0, dv1, srt_out, srt_out_valid,
    input  gnt0, gnt1, srt_in, srt_in_valid, dout, dout_valid, dout_id, busy, err
  );

  modport slave (
    input  req0, req1, din0, din1, dv0, dv1, srt_out, srt_out_valid,
    output gnt0, gnt1, srt_in, srt_in_valid, dout, dout_valid, dout_id, busy, err
  );
endinterface

// File: rtl/sorter_share_ctrl.sv
// sorter_share_ctrl: round-robin per-frame scheduler sharing one sorter between two requesters.
// Latency: grant 1 cycle after request sampled; feed and drain paths 1 cycle; all outputs registered.
// Backpressure: none; a granted frame runs to completion, the other requester waits at its req level.
// Ports: CLK, RESET (async active-low), bus (sorter_share_ctrl_if.slave).
// Optional macro SORT_SHARE_TIMEOUT_EN: WAIT watchdog of TIMEOUT cycles raising err and aborting the frame.
module sorter_share_ctrl #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4,
  parameter int TIMEOUT   = 64
) (
  input logic                 CLK,
  input logic                 RESET,
  sorter_share_ctrl_if.slave  bus
);

  // Elaboration-time guard on the parameter set.
  if (FRAME_LEN < 2 || (2 ** CNT_W) <= FRAME_LEN || TIMEOUT < 1) begin : g_cfg_err
    $error("sorter_share_ctrl: invalid FRAME_LEN/CNT_W/TIMEOUT");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_WAIT, ST_DRAIN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t            state;
  logic              rr_ptr;
  logic              gidx;
  logic [CNT_W-1:0]  feed_cnt;
  logic [CNT_W-1:0]  drain_cnt;

  // Requester picked in IDLE: the lone requester, or rr_ptr when both ask.
  logic              pick;
  logic              dv_sel;
  logic signed [7:0] din_sel;

  assign pick    = (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
  assign dv_sel  = gidx ? bus.dv1  : bus.dv0;
  assign din_sel = gidx ? bus.din1 : bus.din0;

`ifdef SORT_SHARE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state            <= ST_IDLE;
      rr_ptr           <= 1'b0;
      gidx             <= 1'b0;
      feed_cnt         <= '0;
      drain_cnt        <= '0;
      bus.gnt0         <= 1'b0;
      bus.gnt1         <= 1'b0;
      bus.srt_in       <= '0;
      bus.srt_in_valid <= 1'b0;
      bus.dout         <= '0;
      bus.dout_valid   <= 1'b0;
      bus.dout_id      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.err          <= 1'b0;
`ifdef SORT_SHARE_TIMEOUT_EN
      wcnt             <= '0;
`endif
    end else begin
      // Valids and err are single-cycle unless re-asserted below.
      bus.srt_in_valid <= 1'b0;
      bus.dout_valid   <= 1'b0;
      bus.err          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req0 || bus.req1) begin
            gidx      <= pick;
            bus.gnt0  <= ~pick;
            bus.gnt1  <= pick;
            bus.busy  <= 1'b1;
            feed_cnt  <= '0;
            drain_cnt <= '0;
            state     <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (dv_sel) begin
            bus.srt_in       <= din_sel;
            bus.srt_in_valid <= 1'b1;
            feed_cnt         <= feed_cnt + 1'b1;
            if (feed_cnt == LAST) begin
              state <= ST_WAIT;
`ifdef SORT_SHARE_TIMEOUT_EN
              wcnt  <= '0;
`endif
            end
          end
        end
        ST_WAIT: begin
          // The first result beat is taken in the same cycle it shows up.
          if (bus.srt_out_valid) begin
            bus.dout       <= bus.srt_out;
            bus.dout_valid <= 1'b1;
            bus.dout_id    <= gidx;
            drain_cnt      <= CNT_W'(1);
            state          <= ST_DRAIN;
          end
`ifdef SORT_SHARE_TIMEOUT_EN
          else if (wcnt == TW'(TIMEOUT - 1)) begin
            bus.err   <= 1'b1;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.busy  <= 1'b0;
            rr_ptr    <= ~gidx;
            feed_cnt  <= '0;
            drain_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        ST_DRAIN: begin
          if (bus.srt_out_valid) begin
            bus.dout       <= bus.srt_out;
            bus.dout_valid <= 1'b1;
            bus.dout_id    <= gidx;
            drain_cnt      <= drain_cnt + 1'b1;
            if (drain_cnt == LAST) begin
              bus.gnt0  <= 1'b0;
              bus.gnt1  <= 1'b0;
              bus.busy  <= 1'b0;
              rr_ptr    <= ~gidx;
              feed_cnt  <= '0;
              drain_cnt <= '0;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_share_ctrl.sv
// tb_sorter_share_ctrl: directed bench for sorter_share_ctrl with a behavioural sorter model.
// The sorter model collects 8 in_valid beats, sorts them and returns them as an 8-beat burst.
// Expected values are hand-written tables; every comparison goes through chk().
module tb_sorter_share_ctrl;

  logic clk;
  logic rst_n;

  sorter_share_ctrl_if bus ();

  sorter_share_ctrl #(.FRAME_LEN(8), .CNT_W(4), .TIMEOUT(64)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Requester 0 frame, requester 1 frame, and their hand-sorted results.
  int va [8] = '{5, -3, 127, -128, 0, 9, -1, 2};
  int sa [8] = '{-128, -3, -1, 0, 2, 5, 9, 127};
  int vb [8] = '{10, 20, -10, -20, 30, -30, 1, 0};
  int sb [8] = '{-30, -20, -10, 0, 1, 10, 20, 30};

  bit sorter_en = 1'b1;
  bit stray     = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return int'({bus.gnt0, bus.gnt1, bus.srt_in, bus.srt_in_valid, bus.dout,
                 bus.dout_valid, bus.dout_id, bus.busy, bus.err});
  endfunction

  // Sorter model
  int cap [8];
  int srt_buf [8];
  int n_cap, dly, ret_cnt, t;
  initial begin
    bus.srt_out       = '0;
    bus.srt_out_valid = 1'b0;
    n_cap = 0; dly = 0; ret_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.srt_out_valid = 1'b0;
      if (!rst_n) begin
        n_cap = 0; dly = 0; ret_cnt = 0;
      end else begin
        if (bus.srt_in_valid && n_cap < 8) begin
          cap[n_cap] = int'(bus.srt_in);
          n_cap++;
          if (n_cap == 8) begin
            srt_buf = cap;
            for (int i = 1; i < 8; i++)
              for (int j = i; j > 0 && srt_buf[j-1] > srt_buf[j]; j--) begin
                t = srt_buf[j]; srt_buf[j] = srt_buf[j-1]; srt_buf[j-1] = t;
              end
            n_cap = 0;
            if (sorter_en) dly = 3;
          end
        end
        if (dly > 0) begin
          dly--;
          if (dly == 0) ret_cnt = 8;
        end
        if (ret_cnt > 0) begin
          bus.srt_out       = 8'(srt_buf[8-ret_cnt]);
          bus.srt_out_valid = 1'b1;
          ret_cnt--;
        end else if (stray) begin
          bus.srt_out       = 8'sd99;
          bus.srt_out_valid = 1'b1;
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.dv0  = 1'b0; bus.dv1  = 1'b0;
    bus.din0 = '0;   bus.din1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(output int id);
    int w = 0;
    do begin
      tick();
      w++;
    end while (!(bus.gnt0 || bus.gnt1) && w < 5);
    chk("gnt_wait", int'(bus.gnt0 || bus.gnt1), 1);
    id = int'(bus.gnt1);
  endtask

  // Stream nb beats of requester id's frame; the other requester drives junk 77,
  // and at beat intr it raises req with din 55.
  task automatic feed(input int id, input int nb, input int intr);
    if (id == 0) begin bus.dv1 = 1'b1; bus.din1 = 8'sd77; end
    else         begin bus.dv0 = 1'b1; bus.din0 = 8'sd77; end
    for (int i = 0; i < nb; i++) begin
      if (id == 0) begin bus.dv0 = 1'b1; bus.din0 = 8'(va[i]); end
      else         begin bus.dv1 = 1'b1; bus.din1 = 8'(vb[i]); end
      if (i == intr) begin bus.req1 = 1'b1; bus.dv1 = 1'b1; bus.din1 = 8'sd55; end
      tick();
      chk($sformatf("srt_in_r%0d_b%0d", id, i), int'(bus.srt_in), (id == 0) ? va[i] : vb[i]);
      chk($sformatf("srt_vld_r%0d_b%0d", id, i), int'(bus.srt_in_valid), 1);
      chk($sformatf("other_gnt_r%0d_b%0d", id, i), int'((id == 0) ? bus.gnt1 : bus.gnt0), 0);
    end
    bus.dv0 = 1'b0;
    bus.dv1 = 1'b0;
  endtask

  task automatic drain(input int id);
    int w = 0;
    while (!bus.dout_valid && w < 60) begin
      tick();
      w++;
    end
    chk("drain_start", int'(bus.dout_valid), 1);
    if (bus.dout_valid) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("dout_r%0d_b%0d", id, i), int'(bus.dout), (id == 0) ? sa[i] : sb[i]);
        chk($sformatf("dout_vld_r%0d_b%0d", id, i), int'(bus.dout_valid), 1);
        chk($sformatf("dout_id_r%0d_b%0d", id, i), int'(bus.dout_id), id);
        if (i < 7) tick();
      end
      chk($sformatf("gnt_drop_r%0d", id), int'({bus.gnt0, bus.gnt1}), 0);
      chk($sformatf("busy_drop_r%0d", id), int'(bus.busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int id;
    bit seen_err;
    rst_n = 1'b0;
    clear_inputs();

    // 1: reset with random inputs, then idle with no request.
    for (int i = 0; i < 3; i++) begin
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      bus.dv0  = 1'($urandom_range(0, 1));
      bus.dv1  = 1'($urandom_range(0, 1));
      bus.din0 = 8'($urandom);
      bus.din1 = 8'($urandom);
      tick();
      chk($sformatf("rst_outs_%0d", i), outs(), 0);
    end
    clear_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_gnt_%0d", i), int'({bus.gnt0, bus.gnt1}), 0);
    end
    // Result valid from the sorter while idle is ignored.
    stray = 1'b1;
    tick();
    chk("stray_dv_a", int'(bus.dout_valid), 0);
    tick();
    chk("stray_dv_b", int'(bus.dout_valid), 0);
    stray = 1'b0;
    tick();
    chk("stray_dv_c", int'(bus.dout_valid), 0);
    tick();
    chk("stray_dv_d", int'(bus.dout_valid), 0);

    // 2: single frame from requester 0.
    bus.req0 = 1'b1;
    tick();
    chk("t2_gnt0", int'(bus.gnt0), 1);
    chk("t2_busy", int'(bus.busy), 1);
    bus.req0 = 1'b0;
    feed(0, 8, -1);
    drain(0);

    // 3: both requesting for four frames alternate 0,1,0,1.
    do_reset();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(id);
      chk($sformatf("rr_order_%0d", k), id, k % 2);
      feed(id, 8, -1);
      drain(id);
      if (k == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
    tick();
    chk("t3_idle", int'({bus.gnt0, bus.gnt1}), 0);

    // 4: req1 arriving during req0's frame waits for the drain to finish.
    bus.req0 = 1'b1;
    wait_gnt(id);
    chk("t4_owner", id, 0);
    bus.req0 = 1'b0;
    feed(0, 8, 2);
    drain(0);
    tick();
    chk("t4_gnt1_after", int'(bus.gnt1), 1);

    // 5: asynchronous reset three beats into req1's frame, then a full req1 frame.
    feed(1, 3, -1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rst", outs(), 0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.req1 = 1'b1;
    wait_gnt(id);
    chk("t5_owner", id, 1);
    bus.req1 = 1'b0;
    feed(1, 8, -1);
    drain(1);

    // 6: sorter never answers.
    do_reset();
    sorter_en = 1'b0;
    bus.req0 = 1'b1;
    wait_gnt(id);
    bus.req0 = 1'b0;
    feed(0, 8, -1);
    seen_err = 1'b0;
`ifdef SORT_SHARE_TIMEOUT_EN
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k < 64 && bus.err) seen_err = 1'b1;
    end
    chk("t6_no_early_err", int'(seen_err), 0);
    chk("t6_err_pulse", int'(bus.err), 1);
    chk("t6_gnt_rel", int'({bus.gnt0, bus.gnt1}), 0);
    chk("t6_busy_rel", int'(bus.busy), 0);
    tick();
    chk("t6_err_one_cycle", int'(bus.err), 0);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.err) seen_err = 1'b1;
    end
    chk("t6_no_err", int'(seen_err), 0);
    chk("t6_busy_held", int'(bus.busy), 1);
    chk("t6_gnt_held", int'(bus.gnt0), 1);
`endif
    sorter_en = 1'b1;
    do_reset();
    tick();
    chk("end_idle", outs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
